tc_xact_tracker: RTL and testbench

Synthesizable, parametrised TileLink acquire/grant traffic engine for tag-cache performance benches. It sits between a trace request stream and the tag cache's uncached acquire/grant ports. It supports up to MAX_OUT concurrent transactions, multi-beat put-block issue and per-transaction grant-beat tracking. It accumulates completion count and latency statistics in hardware.

---
 rtl/tc_xact_tracker_if.sv | 44 ++++
 rtl/tc_xact_tracker.sv | 180 ++++++++++++++++++
 tb/tb_tc_xact_tracker.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tc_xact_tracker_if.sv
// Trace-request, acquire and grant signal bundle for tc_xact_tracker.
// The master modport is the tracker itself; slave is the trace source / tag cache side.
interface tc_xact_tracker_if #(
    parameter int ADDR_W = 26,
    parameter int ID_W   = 7,
    parameter int BEATS  = 8
);
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr_block;
    logic [2:0]        req_a_type;

    logic              acq_valid;
    logic              acq_ready;
    logic [ADDR_W-1:0] acq_addr_block;
    logic [ID_W-1:0]   acq_xact_id;
    logic [BW-1:0]     acq_addr_beat;
    logic [2:0]        acq_a_type;

    logic              gnt_valid;
    logic              gnt_ready;
    logic [ID_W-1:0]   gnt_xact_id;
    logic [BW-1:0]     gnt_addr_beat;

    modport master (
        input  req_valid, req_addr_block, req_a_type,
        output req_ready,
        output acq_valid, acq_addr_block, acq_xact_id, acq_addr_beat, acq_a_type,
        input  acq_ready,
        input  gnt_valid, gnt_xact_id, gnt_addr_beat,
        output gnt_ready
    );

    modport slave (
        output req_valid, req_addr_block, req_a_type,
        input  req_ready,
        input  acq_valid, acq_addr_block, acq_xact_id, acq_addr_beat, acq_a_type,
        output acq_ready,
        output gnt_valid, gnt_xact_id, gnt_addr_beat,
        input  gnt_ready
    );
endinterface

// File: rtl/tc_xact_tracker.sv
// TileLink acquire/grant traffic engine: issues trace requests into slot-tracked
// acquires, retires them on grant beats and accumulates latency statistics.
module tc_xact_tracker #(
    parameter int ADDR_W  = 26,
    parameter int ID_W    = 7,
    parameter int MAX_OUT = 8,
    parameter int BEATS   = 8,
    parameter int LAT_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    tc_xact_tracker_if.master          bus,
    output logic [$clog2(MAX_OUT):0]   outstanding,
    output logic [LAT_W-1:0]           stat_done,
    output logic [LAT_W+15:0]          stat_lat_sum,
    output logic [LAT_W-1:0]           stat_lat_max,
    output logic                       err_unexp,
    output logic                       idle
);
    localparam int SW    = $clog2(MAX_OUT);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SUM_W = LAT_W + 16;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    localparam logic [2:0] T_GET_BLOCK = 3'd1;
    localparam logic [2:0] T_PUT_BLOCK = 3'd3;

    localparam logic [BW:0]      CNT_ONE  = (BW+1)'(1);
    localparam logic [BW:0]      CNT_BLK  = (BW+1)'(BEATS);
    localparam logic [BW-1:0]    LAST_BT  = BW'(BEATS - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [SW:0]      OUT_ONE  = (SW+1)'(1);

    logic [0:0]         state;
    logic [LAT_W-1:0]   now;
    logic [MAX_OUT-1:0] busy;
    logic [MAX_OUT-1:0] started;
    logic [MAX_OUT-1:0] is_blk;
    logic [BW:0]        gcnt    [MAX_OUT];
    logic [LAT_W-1:0]   t_start [MAX_OUT];

    logic              acq_valid_q;
    logic [ADDR_W-1:0] acq_addr_q;
    logic [2:0]        acq_type_q;
    logic [BW-1:0]     acq_beat_q;
    logic [SW-1:0]     cur_slot;

    logic [SW-1:0]    free_idx;
    logic             any_free;
    logic             req_ready_w;
    logic             req_fire;
    logic             acq_fire;
    logic [SW-1:0]    g_slot;
    logic             g_in_range;
    logic             g_ok;
    logic             g_done;
    logic [BW:0]      g_need;
    logic [LAT_W-1:0] g_lat;
    logic [SUM_W:0]   sum_ext;
    logic             unused_gnt_beat;

    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int unsigned i = 0; i < MAX_OUT; i++) begin
            if (!busy[i] && !any_free) begin
                free_idx = SW'(i);
                any_free = 1'b1;
            end
        end
    end

    // Gated by reset so every handshake output reads 0 while reset is held.
    assign req_ready_w = !reset && (state == S_IDLE) && any_free;
    assign req_fire    = bus.req_valid && req_ready_w;
    assign acq_fire    = acq_valid_q && bus.acq_ready;

    // A slot only accepts grants once its first acquire beat has gone out.
    assign g_slot     = bus.gnt_xact_id[SW-1:0];
    assign g_in_range = 32'(bus.gnt_xact_id) < 32'(MAX_OUT);
    assign g_ok       = bus.gnt_valid && g_in_range && busy[g_slot] && started[g_slot];
    assign g_need     = is_blk[g_slot] ? CNT_BLK : CNT_ONE;
    assign g_done     = g_ok && ((gcnt[g_slot] + CNT_ONE) == g_need);
    assign g_lat      = now - t_start[g_slot];
    assign sum_ext    = {1'b0, stat_lat_sum} + (SUM_W+1)'(g_lat);

    assign unused_gnt_beat = ^bus.gnt_addr_beat;

    assign bus.req_ready      = req_ready_w;
    assign bus.gnt_ready      = !reset;
    assign bus.acq_valid      = acq_valid_q;
    assign bus.acq_addr_block = acq_addr_q;
    assign bus.acq_xact_id    = ID_W'(cur_slot);
    assign bus.acq_addr_beat  = acq_beat_q;
    assign bus.acq_a_type     = acq_type_q;

    assign idle = (state == S_IDLE) && (outstanding == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            now          <= '0;
            busy         <= '0;
            started      <= '0;
            is_blk       <= '0;
            acq_valid_q  <= 1'b0;
            acq_addr_q   <= '0;
            acq_type_q   <= '0;
            acq_beat_q   <= '0;
            cur_slot     <= '0;
            outstanding  <= '0;
            stat_done    <= '0;
            stat_lat_sum <= '0;
            stat_lat_max <= '0;
            err_unexp    <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                gcnt[i]    <= '0;
                t_start[i] <= '0;
            end
        end else begin
            now <= now + LAT_ONE;

            case (state)
                S_IDLE: begin
                    if (req_fire) begin
                        state            <= S_ISSUE;
                        acq_valid_q      <= 1'b1;
                        acq_addr_q       <= bus.req_addr_block;
                        acq_type_q       <= bus.req_a_type;
                        acq_beat_q       <= '0;
                        cur_slot         <= free_idx;
                        busy[free_idx]   <= 1'b1;
                        started[free_idx] <= 1'b0;
                        is_blk[free_idx] <= (bus.req_a_type == T_GET_BLOCK);
                        gcnt[free_idx]   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (acq_fire) begin
                        if (acq_beat_q == '0) begin
                            started[cur_slot] <= 1'b1;
                            t_start[cur_slot] <= now;
                        end
                        if ((acq_type_q == T_PUT_BLOCK) && (acq_beat_q != LAST_BT)) begin
                            acq_beat_q <= acq_beat_q + BW'(1);
                        end else begin
                            state       <= S_IDLE;
                            acq_valid_q <= 1'b0;
                        end
                    end
                end
            endcase

            if (g_ok) begin
                if (g_done) begin
                    busy[g_slot] <= 1'b0;
                    stat_done    <= stat_done + LAT_ONE;
                    stat_lat_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
                    if (g_lat > stat_lat_max) begin
                        stat_lat_max <= g_lat;
                    end
                end else begin
                    gcnt[g_slot] <= gcnt[g_slot] + CNT_ONE;
                end
            end

            if (bus.gnt_valid && !g_ok) begin
                err_unexp <= 1'b1;
            end

            if (req_fire && !g_done) begin
                outstanding <= outstanding + OUT_ONE;
            end else if (!req_fire && g_done) begin
                outstanding <= outstanding - OUT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_tc_xact_tracker.sv
// Bench for tc_xact_tracker: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_tc_xact_tracker;
    localparam int ADDR_W  = 26;
    localparam int ID_W    = 7;
    localparam int MAX_OUT = 8;
    localparam int BEATS   = 8;
    localparam int LAT_W   = 32;
    localparam int SW      = 3;
    localparam longint unsigned SUM_MAX = (64'd1 << 48) - 64'd1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tc_xact_tracker_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .BEATS(BEATS)) bus ();

    logic [SW:0]        outstanding;
    logic [LAT_W-1:0]   stat_done;
    logic [LAT_W+15:0]  stat_lat_sum;
    logic [LAT_W-1:0]   stat_lat_max;
    logic               err_unexp;
    logic               idle;

    tc_xact_tracker #(
        .ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_OUT(MAX_OUT), .BEATS(BEATS), .LAT_W(LAT_W)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .outstanding(outstanding), .stat_done(stat_done), .stat_lat_sum(stat_lat_sum),
        .stat_lat_max(stat_lat_max), .err_unexp(err_unexp), .idle(idle)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each slot is a pending transaction record; the issuer
    // is a single in-flight request with a count of beats sent.
    bit               m_busy    [MAX_OUT];
    bit               m_started [MAX_OUT];
    int unsigned      m_need    [MAX_OUT];
    int unsigned      m_got     [MAX_OUT];
    logic [31:0]      m_start   [MAX_OUT];
    logic [31:0]      m_now;
    bit               m_iss;
    int unsigned      m_slot;
    logic [25:0]      m_addr;
    logic [2:0]       m_type;
    int unsigned      m_sent;
    int unsigned      m_total;
    logic [31:0]      m_done;
    logic [31:0]      m_max;
    logic [47:0]      m_sum;
    bit               m_err;

    function automatic int unsigned m_count();
        int unsigned n = 0;
        for (int i = 0; i < MAX_OUT; i++) n += m_busy[i];
        return n;
    endfunction

    function automatic bit m_req_ready();
        return !reset && !m_iss && (m_count() < MAX_OUT);
    endfunction

    function automatic int unsigned lowest_free();
        for (int i = 0; i < MAX_OUT; i++) if (!m_busy[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MAX_OUT; i++) begin
            m_busy[i] = 0; m_started[i] = 0; m_need[i] = 0; m_got[i] = 0; m_start[i] = '0;
        end
        m_now = '0; m_iss = 0; m_slot = 0; m_addr = '0; m_type = '0; m_sent = 0; m_total = 0;
        m_done = '0; m_max = '0; m_sum = '0; m_err = 0;
    endtask

    task automatic model_step();
        int unsigned id, fr;
        bit rr;
        logic [31:0] lat;
        longint unsigned s;
        if (reset) begin
            model_reset();
            return;
        end
        rr = m_req_ready();
        fr = lowest_free();
        if (bus.gnt_valid) begin
            id = bus.gnt_xact_id;
            if (id >= MAX_OUT) m_err = 1;
            else if (!m_busy[id] || !m_started[id]) m_err = 1;
            else begin
                m_got[id]++;
                if (m_got[id] == m_need[id]) begin
                    lat = m_now - m_start[id];
                    m_busy[id] = 0;
                    m_done = m_done + 1;
                    s = longint'(m_sum) + longint'(lat);
                    m_sum = (s > SUM_MAX) ? 48'hFFFF_FFFF_FFFF : s[47:0];
                    if (lat > m_max) m_max = lat;
                end
            end
        end
        if (m_iss && bus.acq_ready) begin
            if (m_sent == 0) begin
                m_started[m_slot] = 1;
                m_start[m_slot] = m_now;
            end
            m_sent++;
            if (m_sent == m_total) m_iss = 0;
        end
        if (bus.req_valid && rr) begin
            m_busy[fr] = 1; m_started[fr] = 0; m_got[fr] = 0;
            m_need[fr] = (bus.req_a_type == 3'd1) ? BEATS : 1;
            m_iss = 1; m_slot = fr; m_addr = bus.req_addr_block; m_type = bus.req_a_type;
            m_sent = 0; m_total = (bus.req_a_type == 3'd3) ? BEATS : 1;
        end
        m_now = m_now + 1;
    endtask

    task automatic compare_all();
        check("req_ready", bus.req_ready, m_req_ready());
        check("gnt_ready", bus.gnt_ready, !reset);
        check("acq_valid", bus.acq_valid, m_iss);
        if (m_iss) begin
            check("acq_addr", bus.acq_addr_block, m_addr);
            check("acq_id", bus.acq_xact_id, m_slot);
            check("acq_beat", bus.acq_addr_beat, m_sent);
            check("acq_type", bus.acq_a_type, m_type);
        end
        check("outstanding", outstanding, m_count());
        check("stat_done", stat_done, m_done);
        check("stat_lat_sum", stat_lat_sum, m_sum);
        check("stat_lat_max", stat_lat_max, m_max);
        check("err_unexp", err_unexp, m_err);
        check("idle", idle, !m_iss && (m_count() == 0));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic req(input logic [25:0] addr, input logic [2:0] typ);
        bit hs = 0;
        bus.req_valid = 1'b1; bus.req_addr_block = addr; bus.req_a_type = typ;
        for (int k = 0; k < 100 && !hs; k++) begin
            hs = m_req_ready();
            cycle();
        end
        bus.req_valid = 1'b0;
        if (!hs) check("req_wait", m_req_ready(), 1'b1);
    endtask

    task automatic issue_all();
        bus.acq_ready = 1'b1;
        for (int k = 0; k < 4 * BEATS && m_iss; k++) cycle();
        bus.acq_ready = 1'b0;
        if (m_iss) check("issue_wait", m_iss, 1'b0);
    endtask

    task automatic grant(input int unsigned id);
        bus.gnt_valid = 1'b1;
        bus.gnt_xact_id = ID_W'(id);
        bus.gnt_addr_beat = 3'($urandom);
        cycle();
        bus.gnt_valid = 1'b0;
    endtask

    task automatic drain();
        issue_all();
        for (int id = 0; id < MAX_OUT; id++)
            for (int k = 0; k < BEATS && m_busy[id] && m_started[id]; k++) grant(id);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0] seen[$];
        bit pend;
        int pick;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_addr_block = '0; bus.req_a_type = '0;
        bus.acq_ready = 1'b0;
        bus.gnt_valid = 1'b0; bus.gnt_xact_id = '0; bus.gnt_addr_beat = '0;
        model_reset();

        // Reset state
        repeat (2) cycle();
        check("rst_idle", idle, 1'b1);
        check("rst_acq_valid", bus.acq_valid, 1'b0);
        check("rst_gnt_ready", bus.gnt_ready, 1'b0);
        reset = 1'b0;
        cycle();

        // Single get, grant five cycles after the acquire handshake
        req(26'h100, 3'd0);
        check("get_id", bus.acq_xact_id, 0);
        check("get_beat", bus.acq_addr_beat, 0);
        issue_all();
        repeat (4) cycle();
        grant(0);
        check("get_done", stat_done, 1);
        check("get_lat", stat_lat_sum, 5);
        check("get_idle", idle, 1'b1);

        // putBlock with a toggling acq_ready
        req(26'h2A0, 3'd3);
        for (int c = 0; c < 64 && m_iss; c++) begin
            bus.acq_ready = c[0];
            if (bus.acq_valid && bus.acq_ready) begin
                seen.push_back(bus.acq_addr_beat);
                check("pb_addr", bus.acq_addr_block, 26'h2A0);
                check("pb_id", bus.acq_xact_id, 0);
            end
            cycle();
        end
        bus.acq_ready = 1'b0;
        check("pb_nbeats", seen.size(), 8);
        for (int i = 0; i < seen.size(); i++) check("pb_order", seen[i], i);
        grant(0);
        check("pb_out", outstanding, 0);

        // Fill all slots with getBlocks, grants withheld
        for (int i = 0; i < MAX_OUT; i++) begin
            req(26'h1000 + 26'(i), 3'd1);
            check("fill_id", bus.acq_xact_id, i);
            issue_all();
        end
        bus.req_valid = 1'b1; bus.req_addr_block = 26'h1F00; bus.req_a_type = 3'd1;
        repeat (3) begin
            cycle();
            check("full_ready", bus.req_ready, 1'b0);
        end
        bus.req_valid = 1'b0;
        for (int b = 0; b < BEATS; b++) grant(3);
        check("free3_out", outstanding, 7);
        req(26'h2000, 3'd0);
        check("reuse_id", bus.acq_xact_id, 3);
        issue_all();

        // Unexpected grants
        for (int b = 0; b < BEATS; b++) grant(5);
        check("pre_err", err_unexp, 1'b0);
        grant(5);
        grant(12);
        check("unexp_err", err_unexp, 1'b1);
        check("unexp_done", stat_done, 4);
        check("unexp_out", outstanding, 7);

        // Completion and allocation in the same cycle
        drain();
        check("drain_out", outstanding, 0);
        req(26'h3000, 3'd1);
        issue_all();
        for (int b = 0; b < BEATS - 1; b++) grant(0);
        bus.req_valid = 1'b1; bus.req_addr_block = 26'h3100; bus.req_a_type = 3'd0;
        bus.gnt_valid = 1'b1; bus.gnt_xact_id = '0;
        cycle();
        bus.req_valid = 1'b0; bus.gnt_valid = 1'b0;
        check("same_id", bus.acq_xact_id, 1);
        check("same_out", outstanding, 1);
        issue_all();

        // Reset mid-burst with four slots busy
        req(26'h3200, 3'd1); issue_all();
        req(26'h3300, 3'd1); issue_all();
        req(26'h3400, 3'd3);
        bus.acq_ready = 1'b1;
        repeat (3) cycle();
        check("mid_out", outstanding, 4);
        bus.acq_ready = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rr_done", stat_done, 0);
        check("rr_sum", stat_lat_sum, 0);
        check("rr_acq_valid", bus.acq_valid, 1'b0);
        check("rr_idle", idle, 1'b1);
        req(26'h4000, 3'd0);
        check("rr_id", bus.acq_xact_id, 0);
        issue_all();
        grant(0);

        // Randomized traffic
        pend = 0;
        for (int c = 0; c < 3000; c++) begin
            bit hs;
            if (!pend && ($urandom % 10) < 3) begin
                pend = 1;
                bus.req_valid = 1'b1;
                bus.req_addr_block = 26'($urandom);
                bus.req_a_type = 3'($urandom % 4);
            end
            bus.acq_ready = (($urandom % 10) < 6);
            bus.gnt_valid = 1'b0;
            if (($urandom % 100) < 40) begin
                pick = -1;
                for (int k = 0; k < MAX_OUT; k++) begin
                    int j;
                    j = (c + k) % MAX_OUT;
                    if (pick < 0 && m_busy[j] && m_started[j]) pick = j;
                end
                if (pick >= 0) begin
                    bus.gnt_valid = 1'b1;
                    bus.gnt_xact_id = ID_W'(pick);
                end
            end else if (($urandom % 100) < 3) begin
                bus.gnt_valid = 1'b1;
                bus.gnt_xact_id = ID_W'($urandom);
            end
            bus.gnt_addr_beat = 3'($urandom);
            hs = bus.req_valid && m_req_ready();
            cycle();
            if (hs) begin
                pend = 0;
                bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        bus.gnt_valid = 1'b0;
        drain();
        check("final_out", outstanding, 0);
        check("final_idle", idle, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
